// File: rtl/msp430_pkg.sv
// Shared types and constants for the msp430 data-memory path.
package msp430_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam int PORT_CPU  = 0;
    localparam int PORT_HOST = 1;
    localparam int DM_AW     = 16;
    localparam int DM_DW     = 16;

    // One-hot grant vector for a single selected port index.
    function automatic logic [1:0] port_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Single request wins outright; a tie goes to the port opposite 'last'.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of data_mem: round-robin with bounded locked bursts and a 1-cycle read return.
module dm_port_arbiter
    import msp430_pkg::*;
#(
    parameter int AW        = DM_AW,
    parameter int DW        = DM_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [1:0]    REQ,
    input  logic [1:0]    WE,
    input  logic [1:0]    LOCK,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDAT0,
    input  logic [DW-1:0] WDAT1,
    output logic [1:0]    GNT,
    output logic [1:0]    RVAL,
    output logic [DW-1:0] RDAT,
    output logic [AW-1:0] M_DMAR,
    output logic [AW-1:0] M_DMAW,
    output logic [DW-1:0] M_WD,
    output logic          M_DMS,
    output logic          M_RDV,
    output logic          M_WRV,
    input  logic [DW-1:0] M_RD
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    arb_state_t     state;
    logic [BW-1:0]  bcnt;
    logic           last;
    logic [1:0]     pend;

    logic           own_valid;
    logic           own_port;
    logic           keep;
    logic           rr_last;
    logic [1:0]     pick;
    logic           gnt_any;
    logic           gnt_port;
    logic           we_sel;
    logic [AW-1:0]  addr_sel;
    logic [DW-1:0]  wdat_sel;

    assign own_valid = (state != ARB_IDLE);
    assign own_port  = (state == ARB_OWN1);
    // The owner keeps the port unless its burst is spent while the other side is waiting.
    assign keep      = own_valid && REQ[own_port] && LOCK[own_port]
                       && ((bcnt < MAX_B) || !REQ[~own_port]);
    assign rr_last   = own_valid ? own_port : last;

    rr_pick2 u_pick (
        .req  (REQ),
        .last (rr_last),
        .gnt  (pick)
    );

    // Grant select; reset forces the memory port quiet.
    always_comb begin
        if (RST) begin
            GNT = 2'b00;
        end else if (keep) begin
            GNT = port_onehot(own_port);
        end else begin
            GNT = pick;
        end
    end

    assign gnt_any  = |GNT;
    assign gnt_port = GNT[PORT_HOST];
    assign we_sel   = gnt_port ? WE[PORT_HOST] : WE[PORT_CPU];
    assign addr_sel = gnt_port ? ADDR1 : ADDR0;
    assign wdat_sel = gnt_port ? WDAT1 : WDAT0;

    assign M_DMS  = gnt_any;
    assign M_WRV  = gnt_any & we_sel;
    assign M_RDV  = gnt_any & ~we_sel;
    assign M_DMAW = M_WRV ? addr_sel : {AW{1'b0}};
    assign M_WD   = M_WRV ? wdat_sel : {DW{1'b0}};
    assign M_DMAR = M_RDV ? addr_sel : {AW{1'b0}};

    assign RVAL = pend;
    assign RDAT = (|pend) ? M_RD : {DW{1'b0}};

    // Ownership, burst count, round-robin history and read-return pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ARB_IDLE;
            bcnt  <= {BW{1'b0}};
            last  <= 1'b1;
            pend  <= 2'b00;
        end else begin
            pend <= GNT & ~WE;
            if (gnt_any) begin
                last <= gnt_port;
                if (LOCK[gnt_port]) begin
                    state <= gnt_port ? ARB_OWN1 : ARB_OWN0;
                    if (keep) begin
                        bcnt <= (bcnt == MAX_B) ? bcnt : bcnt + BW'(1);
                    end else begin
                        bcnt <= BW'(1);
                    end
                end else begin
                    state <= ARB_IDLE;
                    bcnt  <= {BW{1'b0}};
                end
            end else begin
                state <= ARB_IDLE;
                bcnt  <= {BW{1'b0}};
            end
        end
    end

endmodule
